// File: rtl/derepeater.sv
// Purpose : collapse each group of N repeated AXI-stream words into one word by per-bit majority vote.
// Latency : 1 clk from the accept of a group's closing sample to axis_out_tvalid.
// Backpr. : samples 0..N-2 always accepted; the closing sample stalls only while the output slot is full and not draining.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   axis_in_*           repeated input samples (tdata/tvalid/tready)
//   align               synchronous resync: drop the partial group, restart counting
//   axis_out_*          voted word, valid/ready, mismatch flag qualified by tvalid
//   recv_cnt            samples accepted so far in the current group
module derepeater #(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_W-1:0]      axis_in_tdata,
    input  logic                   axis_in_tvalid,
    output logic                   axis_in_tready,
    input  logic                   align,
    output logic [DATA_W-1:0]      axis_out_tdata,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic                   axis_out_mismatch,
    output logic [$clog2(N)-1:0]   recv_cnt
);

    localparam int CNT_W  = $clog2(N);
    localparam int ONES_W = $clog2(N + 1);

    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(N - 1);
    localparam logic [ONES_W-1:0] N_ONES  = ONES_W'(N);
    localparam logic [ONES_W:0]   N_DBL   = (ONES_W + 1)'(N);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ONES_W-1:0] ones_q     [DATA_W];
    logic [ONES_W-1:0] ones_d     [DATA_W];
    logic [DATA_W-1:0] first_q,   first_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              out_vld_q, out_vld_d;
    logic              out_mis_q, out_mis_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic in_rdy;
    logic accept;
    logic take;
    logic closing;

    // Ready looks only at registered state and the downstream ready, never
    // at tvalid, so there is no combinational loop through the source.
    assign in_rdy  = (cnt_q != LAST) || !out_vld_q || axis_out_tready;
    assign accept  = axis_in_tvalid && in_rdy;
    // align wins over a coincident accept: that sample is simply dropped.
    assign take    = accept && !align;
    assign closing = take && (cnt_q == LAST);

    // ------------------------------------------------------------------
    // Vote on the completed group (stored counts + the closing sample)
    // ------------------------------------------------------------------
    logic [ONES_W-1:0] ones_fin [DATA_W];
    logic [DATA_W-1:0] vote_dat;
    logic              vote_mis;

    always_comb begin
        vote_dat = '0;
        vote_mis = 1'b0;
        for (int b = 0; b < DATA_W; b++) begin
            ones_fin[b] = ones_q[b] + ONES_W'(axis_in_tdata[b]);
            // Compare 2*ones against N; a tie (even N only) falls back to
            // the first copy of the group.
            if ({ones_fin[b], 1'b0} > N_DBL) begin
                vote_dat[b] = 1'b1;
            end else if ({ones_fin[b], 1'b0} < N_DBL) begin
                vote_dat[b] = 1'b0;
            end else begin
                vote_dat[b] = first_q[b];
            end
            if ((ones_fin[b] != '0) && (ones_fin[b] != N_ONES)) begin
                vote_mis = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Group counter, ones counters, first-sample register
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        for (int b = 0; b < DATA_W; b++) begin
            ones_d[b] = ones_q[b];
        end

        if (align) begin
            cnt_d = '0;
            for (int b = 0; b < DATA_W; b++) begin
                ones_d[b] = '0;
            end
        end else if (take) begin
            if (cnt_q == LAST) begin
                // Group complete: the vote consumed the counts, start fresh.
                cnt_d = '0;
                for (int b = 0; b < DATA_W; b++) begin
                    ones_d[b] = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int b = 0; b < DATA_W; b++) begin
                    ones_d[b] = ones_q[b] + ONES_W'(axis_in_tdata[b]);
                end
                if (cnt_q == '0) begin
                    first_d = axis_in_tdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot: a new word may load in the same cycle the old one drains,
    // which keeps back-to-back groups at full rate.
    // ------------------------------------------------------------------
    always_comb begin
        out_dat_d = out_dat_q;
        out_mis_d = out_mis_q;
        out_vld_d = out_vld_q;
        if (closing) begin
            out_dat_d = vote_dat;
            out_mis_d = vote_mis;
            out_vld_d = 1'b1;
        end else if (out_vld_q && axis_out_tready) begin
            out_vld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            first_q   <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            out_mis_q <= 1'b0;
            for (int b = 0; b < DATA_W; b++) begin
                ones_q[b] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            out_mis_q <= out_mis_d;
            for (int b = 0; b < DATA_W; b++) begin
                ones_q[b] <= ones_d[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axis_in_tready    = in_rdy;
    assign axis_out_tdata    = out_dat_q;
    assign axis_out_tvalid   = out_vld_q;
    assign axis_out_mismatch = out_mis_q;
    assign recv_cnt          = cnt_q;

endmodule
